// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO arbiter: op codes, sizing defaults
// and requester ring indices.
package fifo_pkg;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] OP_INIT     = 3'b000;
    localparam logic [2:0] OP_NO_OP    = 3'b001;
    localparam logic [2:0] OP_WRITE    = 3'b010;
    localparam logic [2:0] OP_WR_ERROR = 3'b011;
    localparam logic [2:0] OP_READ     = 3'b100;
    localparam logic [2:0] OP_RD_ERROR = 3'b101;

    localparam logic [1:0] IDX_W0 = 2'd0;
    localparam logic [1:0] IDX_W1 = 2'd1;
    localparam logic [1:0] IDX_RD = 2'd2;

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker over the ring W0 -> W1 -> RD -> W0: returns the first
// eligible requester strictly after the last granted one.
module fifo_rr_pick
    import fifo_pkg::*;
(
    input  logic [2:0] eligible,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] winner
);

    // Scan the ring starting just after the last granted requester
    always_comb begin
        found  = |eligible;
        winner = IDX_W0;
        case (last)
            IDX_W0: begin
                if (eligible[1]) begin
                    winner = IDX_W1;
                end else if (eligible[2]) begin
                    winner = IDX_RD;
                end else begin
                    winner = IDX_W0;
                end
            end
            IDX_W1: begin
                if (eligible[2]) begin
                    winner = IDX_RD;
                end else if (eligible[0]) begin
                    winner = IDX_W0;
                end else begin
                    winner = IDX_W1;
                end
            end
            default: begin
                // RD, and the unused code 3 which behaves like RD
                if (eligible[0]) begin
                    winner = IDX_W0;
                end else if (eligible[1]) begin
                    winner = IDX_W1;
                end else begin
                    winner = IDX_RD;
                end
            end
        endcase
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter/sequencer for the shared FIFO: one operation per cycle,
// tracks occupancy so writes never hit a full FIFO and reads never an empty one.
module fifo_arbiter
    import fifo_pkg::*;
#(
    parameter int DEPTH_P = DEPTH,
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         wr_req,
    input  logic               rd_req,
    output logic [1:0]         gnt_wr,
    output logic               gnt_rd,
    output logic               wr_en,
    output logic               rd_en,
    output logic               wr_sel,
    output logic [2:0]         op,
    output logic [CNT_W_P-1:0] data_count,
    output logic               full,
    output logic               empty
);

    localparam logic [CNT_W_P-1:0] DEPTH_C = CNT_W_P'(DEPTH_P);
    localparam logic [CNT_W_P-1:0] ZERO_C  = {CNT_W_P{1'b0}};
    localparam logic [CNT_W_P-1:0] ONE_C   = CNT_W_P'(1);

    logic [1:0]         last_r;
    logic               init_pend_r;
    logic               room_s;
    logic               avail_s;
    logic [2:0]         elig_s;
    logic               found_s;
    logic [1:0]         winner_s;
    logic [1:0]         nxt_gnt_wr_s;
    logic               nxt_gnt_rd_s;
    logic               nxt_sel_s;
    logic [2:0]         nxt_op_s;
    logic [CNT_W_P-1:0] nxt_count_s;
    logic [1:0]         nxt_last_s;

    assign room_s  = (data_count != DEPTH_C);
    assign avail_s = (data_count != ZERO_C);
    assign elig_s  = {rd_req & avail_s, wr_req[1] & room_s, wr_req[0] & room_s};

    fifo_rr_pick u_pick (
        .eligible (elig_s),
        .last     (last_r),
        .found    (found_s),
        .winner   (winner_s)
    );

    // Decide this cycle's operation from the pick and the registered count
    always_comb begin
        nxt_gnt_wr_s = 2'b00;
        nxt_gnt_rd_s = 1'b0;
        nxt_sel_s    = wr_sel;
        nxt_count_s  = data_count;
        nxt_last_s   = last_r;
        nxt_op_s     = OP_NO_OP;
        if (found_s) begin
            nxt_last_s = winner_s;
            case (winner_s)
                IDX_W0: begin
                    nxt_gnt_wr_s = 2'b01;
                    nxt_sel_s    = 1'b0;
                    nxt_count_s  = data_count + ONE_C;
                    nxt_op_s     = OP_WRITE;
                end
                IDX_W1: begin
                    nxt_gnt_wr_s = 2'b10;
                    nxt_sel_s    = 1'b1;
                    nxt_count_s  = data_count + ONE_C;
                    nxt_op_s     = OP_WRITE;
                end
                IDX_RD: begin
                    nxt_gnt_rd_s = 1'b1;
                    nxt_count_s  = data_count - ONE_C;
                    nxt_op_s     = OP_READ;
                end
                default: begin
                    nxt_last_s = last_r;
                    nxt_op_s   = OP_NO_OP;
                end
            endcase
        end else if ((|wr_req) && !room_s) begin
            nxt_op_s = OP_WR_ERROR;
        end else if (rd_req && !avail_s) begin
            nxt_op_s = OP_RD_ERROR;
        end else begin
            nxt_op_s = OP_NO_OP;
        end
    end

    // State and output registers; one INIT cycle follows reset release
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r      <= IDX_RD;
            init_pend_r <= 1'b1;
            gnt_wr      <= 2'b00;
            gnt_rd      <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            wr_sel      <= 1'b0;
            op          <= OP_INIT;
            data_count  <= ZERO_C;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else if (init_pend_r) begin
            init_pend_r <= 1'b0;
            gnt_wr      <= 2'b00;
            gnt_rd      <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            op          <= OP_INIT;
        end else begin
            last_r     <= nxt_last_s;
            gnt_wr     <= nxt_gnt_wr_s;
            gnt_rd     <= nxt_gnt_rd_s;
            wr_en      <= |nxt_gnt_wr_s;
            rd_en      <= nxt_gnt_rd_s;
            wr_sel     <= nxt_sel_s;
            op         <= nxt_op_s;
            data_count <= nxt_count_s;
            full       <= (nxt_count_s == DEPTH_C);
            empty      <= (nxt_count_s == ZERO_C);
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: a ring-scan occupancy model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_fifo_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] wr_req;
    logic       rd_req;
    logic [1:0] gnt_wr;
    logic       gnt_rd;
    logic       wr_en;
    logic       rd_en;
    logic       wr_sel;
    logic [2:0] op;
    logic [3:0] data_count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;

    // model state
    int m_cnt  = 0;
    int m_last = 2;
    int m_pend = 1;
    int m_gw   = 0;
    int m_gr   = 0;
    int m_sel  = 0;
    int m_op   = 0;

    fifo_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .gnt_wr     (gnt_wr),
        .gnt_rd     (gnt_rd),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_sel     (wr_sel),
        .op         (op),
        .data_count (data_count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Ring order W0(0) -> W1(1) -> RD(2); pick first eligible after last
    task automatic model_edge(input logic [1:0] w, input logic r, input logic rs);
        int idx;
        int win;
        bit ok;
        bit found;
        if (rs) begin
            m_cnt = 0; m_last = 2; m_pend = 1;
            m_gw = 0; m_gr = 0; m_sel = 0; m_op = 0;
        end else if (m_pend != 0) begin
            m_pend = 0; m_gw = 0; m_gr = 0; m_op = 0;
        end else begin
            found = 1'b0;
            win   = 0;
            for (int k = 1; k <= 3; k++) begin
                idx = (m_last + k) % 3;
                if (idx < 2) ok = (w[idx] == 1'b1) && (m_cnt < 8);
                else         ok = (r == 1'b1) && (m_cnt > 0);
                if (ok && !found) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            m_gw = 0;
            m_gr = 0;
            if (found) begin
                m_last = win;
                if (win < 2) begin
                    m_gw  = 1 << win;
                    m_sel = win;
                    m_cnt = m_cnt + 1;
                    m_op  = 2;
                end else begin
                    m_gr  = 1;
                    m_cnt = m_cnt - 1;
                    m_op  = 4;
                end
            end else if (w != 2'b00 && m_cnt == 8) begin
                m_op = 3;
            end else if (r && m_cnt == 0) begin
                m_op = 5;
            end else begin
                m_op = 1;
            end
        end
    endtask

    task automatic step(input logic [1:0] w, input logic r, input logic rs);
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        reset  = rs;
        @(posedge clk);
        model_edge(w, r, rs);
        #1;
        chk("gnt_wr", int'(gnt_wr), m_gw);
        chk("gnt_rd", int'(gnt_rd), m_gr);
        chk("wr_en", int'(wr_en), (m_gw != 0) ? 1 : 0);
        chk("rd_en", int'(rd_en), m_gr);
        chk("wr_sel", int'(wr_sel), m_sel);
        chk("op", int'(op), m_op);
        chk("data_count", int'(data_count), m_cnt);
        chk("full", int'(full), (m_cnt == 8) ? 1 : 0);
        chk("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
    endtask

    initial begin
        reset  = 1'b1;
        wr_req = 2'b11;
        rd_req = 1'b1;

        // reset held two cycles with all requests high, then one INIT cycle
        step(2'b11, 1'b1, 1'b1);
        chk("rst_op_1", int'(op), 0);
        step(2'b11, 1'b1, 1'b1);
        chk("rst_op_2", int'(op), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        step(2'b11, 1'b1, 1'b0);
        chk("post_rst_op", int'(op), 0);
        chk("post_rst_gnt", int'(gnt_wr), 0);
        chk("post_rst_cnt", int'(data_count), 0);

        // fill from empty with both writers; reader now idle
        step(2'b11, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        chk("fill_first_w0", int'(gnt_wr), 1);
        step(2'b11, 1'b0, 1'b0);
        chk("fill_second_w1", int'(wr_sel), 1);
        for (int i = 0; i < 6; i++) step(2'b11, 1'b0, 1'b0);
        chk("fill_cnt8", int'(data_count), 8);
        chk("fill_full", int'(full), 1);
        step(2'b11, 1'b0, 1'b0);
        chk("full_wr_error", int'(op), 3);
        chk("full_no_gnt", int'(wr_en), 0);
        step(2'b11, 1'b0, 1'b0);

        // fill to 4 via W0, then all three request
        step(2'b01, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b01, 1'b0, 1'b0);
        chk("ring_start_cnt", int'(data_count), 4);
        step(2'b11, 1'b1, 1'b0);
        chk("ring_w1", int'(gnt_wr), 2);
        step(2'b11, 1'b1, 1'b0);
        chk("ring_rd", int'(gnt_rd), 1);
        chk("ring_rd_cnt", int'(data_count), 4);
        step(2'b11, 1'b1, 1'b0);
        chk("ring_w0", int'(gnt_wr), 1);
        for (int i = 0; i < 6; i++) step(2'b11, 1'b1, 1'b0);

        // empty with read only, then one W1 write, then a read
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        chk("empty_rd_error", int'(op), 5);
        chk("empty_no_rd_en", int'(rd_en), 0);
        step(2'b10, 1'b0, 1'b0);
        chk("w1_write_sel", int'(wr_sel), 1);
        chk("w1_write_cnt", int'(data_count), 1);
        step(2'b00, 1'b1, 1'b0);
        chk("read_op", int'(op), 4);
        chk("read_cnt", int'(data_count), 0);

        // full with everybody requesting: reader first, then W0
        step(2'b11, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        chk("full_rd_gnt", int'(gnt_rd), 1);
        chk("full_rd_cnt", int'(data_count), 7);
        step(2'b11, 1'b1, 1'b0);
        chk("after_rd_w0", int'(gnt_wr), 1);
        chk("after_rd_cnt", int'(data_count), 8);

        // reset mid-write at count 5
        step(2'b01, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b01, 1'b0, 1'b0);
        chk("pre_rst_cnt5", int'(data_count), 5);
        step(2'b01, 1'b0, 1'b1);
        chk("mid_rst_cnt", int'(data_count), 0);
        chk("mid_rst_op", int'(op), 0);
        chk("mid_rst_en", int'(wr_en), 0);
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        chk("post_rst_w0", int'(gnt_wr), 1);
        step(2'b00, 1'b0, 1'b0);
        chk("idle_no_op", int'(op), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Arbiter and sequencer for the shared 8-entry FIFO. It takes item-level requests from two write clients and one read client and issues at most one FIFO operation per cycle, using round-robin arbitration. It keeps its own occupancy count, so no client is granted a write into a full FIFO or a read from an empty one. It drives the FIFO's write/read enables, the write-data mux select and the 3-bit operation code consumed by the FIFO status logic.

## Interface
- DEPTH, 8, FIFO capacity in entries.
- CNT_W, 4, occupancy counter width; must hold 0..DEPTH.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  2  per-writer request; bit i is writer i.
- rd_req  in  1  reader request.
- gnt_wr  out  2  one-hot writer grant; the write happens in this cycle.
- gnt_rd  out  1  reader grant; the read happens in this cycle.
- wr_en  out  1  FIFO write enable; equals |gnt_wr.
- rd_en  out  1  FIFO read enable; equals gnt_rd.
- wr_sel  out  1  write-data mux select; index of the granted writer, holds its last value otherwise.
- op  out  3  FIFO operation code for the current cycle.
- data_count  out  CNT_W  occupancy after the current cycle's operation.
- full  out  1  data_count == DEPTH.
- empty  out  1  data_count == 0.

## Operation
- Op codes: INIT 000, NO_OP 001, WRITE 010, WR_ERROR 011, READ 100, RD_ERROR 101.
- Requesters are ordered in a ring: W0 -> W1 -> RD -> W0.
- A pointer `last` records the most recently granted requester. On reset, last = RD, so W0 has top priority.
- Eligibility is evaluated against the registered data_count:
  - a writer is eligible when its wr_req = 1 and data_count < DEPTH;
  - the reader is eligible when rd_req = 1 and data_count > 0.
- Each edge grants the first eligible requester after `last` in ring order.
- Outcome of the grant at each edge:
  - Writer granted: op = WRITE, data_count + 1, last updated.
  - Reader granted: op = READ, data_count - 1, last updated.
  - None eligible, and some writer is requesting while full: op = WR_ERROR.
  - Otherwise none eligible, and the reader is requesting while empty: op = RD_ERROR.
  - Otherwise: op = NO_OP.
  - In every no-grant case, data_count and last are unchanged.
- Read and write are never granted in the same cycle. data_count never exceeds DEPTH and never drops below 0.
- Requests are item-level. A client with no further item must deassert req during its grant cycle; a held req is treated as a new request.
- Reset mid-operation:
  - clears data_count and resets `last` to RD;
  - drops every grant and enable;
  - sets op = INIT.
  - The FIFO storage must share the same reset.

## Timing
- All outputs are registered.
- Reset values: gnt_wr = 00, gnt_rd = 0, wr_en = 0, rd_en = 0, wr_sel = 0, op = INIT, data_count = 0, full = 0, empty = 1.
- op = INIT for every cycle reset is high. After reset deasserts, op is INIT for one more cycle, then normal operation begins.
- Latency: a request sampled at edge N produces its grant, enables and op during cycle N..N+1 (one cycle).
- data_count, full and empty update on the same edge as the grant, so they reflect the FIFO state after that cycle's operation.
- Throughput: one operation per cycle. Continuous requests are served back-to-back with no bubbles.
- Boundary cases:
  - At full: writers are skipped, and a pending read is served in the same cycle.
  - At empty: the reader is skipped, and a pending write is served.

## Structure
- The shared package fifo_pkg holds:
  - the six op code parameters;
  - DEPTH and CNT_W defaults;
  - requester index constants IDX_W0 = 0, IDX_W1 = 1, IDX_RD = 2.
- One combinational sub-module, fifo_rr_pick:
  - inputs: 3-bit eligible vector and 2-bit last;
  - outputs: found flag and 2-bit winner index.
- The top level holds the counter, pointer, output registers and op encoding.

## Test plan
- Reset held 2 cycles with all reqs high -> gnt = 0, op = INIT on both cycles and one cycle after release, data_count = 0, empty = 1.
- From empty, wr_req = 11 continuously -> grants W0, W1 alternating, wr_sel 0, 1, 0, ...; data_count 1..8; full = 1 after the 8th grant; then op = WR_ERROR every cycle with no grants.
- After reset, fill to data_count 4, then hold all three reqs -> grant order continues W0 -> W1 -> RD from the last granted requester; data_count steps +1, +1, -1 each round.
- Empty with rd_req only -> op = RD_ERROR, rd_en = 0. Then one cycle of wr_req[1] -> WRITE with wr_sel = 1, data_count = 1; the next cycle grants RD, data_count = 0, op = READ.
- Full with wr_req = 11 and rd_req = 1 -> RD granted immediately, data_count = 7; the next grant goes to the writer after RD in ring order (W0), data_count = 8.
- Reset asserted at data_count = 5 during a WRITE -> next cycle data_count = 0, op = INIT, no enables; the first post-reset grant goes to W0.
